rgb2yuv_encoder: RTL and testbench
==================================

RGB2YUV_ENCODER -- requirements
Module: rgb2yuv_encoder

Interface
REQ-001 Parameter FULL_RANGE, default 0; 0 = BT.601 studio range, 1 = full range (JFIF).
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 R_in, G_in, B_in  input  8 each  unsigned source pixel.
REQ-005 in_valid  input  1  source pixel valid.
REQ-006 in_ready  output  1  block accepts pixel this cycle.
REQ-007 in_sol  input  1  start of line, qualified by in_valid && in_ready.
REQ-008 Y_out, U_out, V_out  output  8 each  encoded pixel.
REQ-009 out_valid  output  1  output pixel valid.
REQ-010 out_ready  input  1  sink accepts pixel this cycle.

Function
REQ-011 Transfer occurs on valid && ready at a clock edge; a pixel is never dropped, duplicated or reordered.
REQ-012 Pipeline enable en = !out_valid || out_ready; in_ready = en; all stages advance only when en = 1.
REQ-013 Stage 1 registers the nine coefficient products; stage 2 registers signed sums plus 128; stage 3 applies arithmetic >>8, offset and clamp, and registers outputs; latency is 3 cycles with out_ready held high.
REQ-014 Studio range: Y = ((66R+129G+25B+128)>>>8)+16; U = ((-38R-74G+112B+128)>>>8)+128; V = ((112R-94G-18B+128)>>>8)+128.
REQ-015 Full range: Y = (77R+150G+29B+128)>>>8; U = ((-43R-85G+128B+128)>>>8)+128; V = ((128R-107G-21B+128)>>>8)+128.
REQ-016 Intermediates are at least 18-bit signed; >>> is arithmetic (floor).
REQ-017 Clamp ranges: studio Y 16..235, U/V 16..240; full range 0..255 for all outputs.
REQ-018 Each stage carries a valid bit; a bubble (in_valid = 0 while en = 1) propagates as an invalid stage and never raises out_valid.
REQ-019 While out_valid && !out_ready, Y_out/U_out/V_out hold stable and in_ready = 0.

Reset
REQ-020 While rst_n = 0: all stage valid bits 0, out_valid 0, Y_out/U_out/V_out 0, and pairing state even/empty.
REQ-021 Assertion mid-stream discards all in-flight pixels; the first pixel accepted after release is treated as line-start parity.
REQ-022 in_ready is high in the first cycle after rst_n deasserts.

Configuration
REQ-023 Macro YUV422_CHROMA_EN, when defined, adds a pair stage after stage 3; when undefined, behaviour is exactly REQ-011..REQ-019.
REQ-024 With the macro defined, pixels are paired even/odd; parity resets to even on accepted in_sol.
REQ-025 An even pixel is held (out_valid = 0) until its odd partner leaves stage 3.
REQ-026 Both pixels of a pair are emitted with U = (U0+U1+1)>>1 and V = (V0+V1+1)>>1, even pixel first, odd pixel on the next transfer.
REQ-027 If a pixel with in_sol reaches the pair stage while an even pixel is held, the held pixel is emitted first with its own unaveraged chroma.
REQ-028 The pair stage stalls the pipeline (en = 0) while it holds two pixels awaiting output; latency is 4 cycles for the odd pixel.

Verification
REQ-029 Studio, RGB (0,0,0) then (255,255,255), out_ready = 1 -> YUV (16,128,128) then (235,128,128), each 3 cycles after acceptance.
REQ-030 Studio, RGB (255,0,0) -> (82,90,240); RGB (0,0,255) -> (41,240,110).
REQ-031 FULL_RANGE = 1, RGB (255,255,255) -> (255,128,128); RGB (0,0,0) -> (0,128,128).
REQ-032 Stream 10 pixels; hold out_ready = 0 for 5 cycles mid-stream -> in_ready = 0 while output is stalled, outputs stable, all 10 results in order with none lost.
REQ-033 Assert rst_n for 1 cycle with 3 pixels in flight -> out_valid = 0 and outputs 0 immediately; none of the 3 pixels ever appears.
REQ-034 YUV422_CHROMA_EN defined, studio, pixels (255,0,0), (0,0,255) with in_sol on the first -> (82,165,175) then (41,165,175).

Source files
------------

// File: rtl/rgb2yuv_encoder.sv
// -----------------------------------------------------------------------------
// rgb2yuv_encoder
//
// Converts 8-bit RGB pixels to 8-bit YCbCr (YUV) through a three-stage
// valid/ready pipeline:
//   stage 1 : nine coefficient products
//   stage 2 : signed sums plus rounding constant 128
//   stage 3 : arithmetic >>8, offset, clamp, registered outputs
// All stages advance together on en = !out_valid || out_ready, and in_ready
// equals en, so the pipeline never drops, duplicates or reorders a pixel.
//
// Parameter
//   FULL_RANGE   0 = BT.601 studio range (Y 16..235, U/V 16..240)
//                1 = full range JFIF (0..255 on every output)
//
// Optional feature (compile-time macro YUV422_CHROMA_EN)
//   Adds a pair stage after stage 3. Pixels are paired even/odd (parity
//   restarts at even on an accepted in_sol). Both pixels of a pair leave with
//   the rounded average of their chroma, even pixel first. An even pixel
//   with no partner, followed by a new line start, leaves with its own chroma.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   R_in, G_in, B_in [7:0]     source pixel
//   in_valid / in_ready        input handshake
//   in_sol                     start of line, qualified by the input handshake
//   Y_out, U_out, V_out [7:0]  encoded pixel
//   out_valid / out_ready      output handshake
// -----------------------------------------------------------------------------
module rgb2yuv_encoder #(
  parameter bit FULL_RANGE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] R_in,
  input  logic [7:0] G_in,
  input  logic [7:0] B_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sol,
  output logic [7:0] Y_out,
  output logic [7:0] U_out,
  output logic [7:0] V_out,
  output logic       out_valid,
  input  logic       out_ready
);

  typedef logic signed [17:0] s18_t;

  // Conversion coefficients (scaled by 256).
  localparam s18_t C_YR = FULL_RANGE ?  18'sd77  :  18'sd66;
  localparam s18_t C_YG = FULL_RANGE ?  18'sd150 :  18'sd129;
  localparam s18_t C_YB = FULL_RANGE ?  18'sd29  :  18'sd25;
  localparam s18_t C_UR = FULL_RANGE ? -18'sd43  : -18'sd38;
  localparam s18_t C_UG = FULL_RANGE ? -18'sd85  : -18'sd74;
  localparam s18_t C_UB = FULL_RANGE ?  18'sd128 :  18'sd112;
  localparam s18_t C_VR = FULL_RANGE ?  18'sd128 :  18'sd112;
  localparam s18_t C_VG = FULL_RANGE ? -18'sd107 : -18'sd94;
  localparam s18_t C_VB = FULL_RANGE ? -18'sd21  : -18'sd18;

  localparam s18_t ROUND = 18'sd128;
  localparam s18_t Y_OFF = FULL_RANGE ? 18'sd0   : 18'sd16;
  localparam s18_t C_OFF = 18'sd128;
  localparam s18_t Y_MIN = FULL_RANGE ? 18'sd0   : 18'sd16;
  localparam s18_t Y_MAX = FULL_RANGE ? 18'sd255 : 18'sd235;
  localparam s18_t C_MIN = FULL_RANGE ? 18'sd0   : 18'sd16;
  localparam s18_t C_MAX = FULL_RANGE ? 18'sd255 : 18'sd240;

  function automatic logic [7:0] clamp8(input s18_t val, input s18_t lo, input s18_t hi);
    if (val < lo)      clamp8 = lo[7:0];
    else if (val > hi) clamp8 = hi[7:0];
    else               clamp8 = val[7:0];
  endfunction

  logic en;
  assign in_ready = en;

  // ---------------------------------------------------------------------------
  // Line parity: next_odd says whether the next accepted pixel is odd.
  // An accepted in_sol forces the pixel to even.
  // ---------------------------------------------------------------------------
  logic next_odd;
  logic pix_odd;
  assign pix_odd = in_sol ? 1'b0 : next_odd;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    next_odd <= 1'b0;
    else if (in_valid && in_ready) next_odd <= !pix_odd;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: products. Pixels are zero-extended into the signed domain.
  // ---------------------------------------------------------------------------
  s18_t px_r, px_g, px_b;
  assign px_r = s18_t'({10'd0, R_in});
  assign px_g = s18_t'({10'd0, G_in});
  assign px_b = s18_t'({10'd0, B_in});

  s18_t s1_p [9];  // order: YR YG YB UR UG UB VR VG VB
  logic s1_valid, s1_odd;

  // NOTE: datapath registers are reset along with the valid bits so that
  // Y/U/V read as 0 during reset rather than stale pixel data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_odd   <= 1'b0;
      for (int i = 0; i < 9; i++) s1_p[i] <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_odd   <= pix_odd;
      s1_p[0]  <= px_r * C_YR;
      s1_p[1]  <= px_g * C_YG;
      s1_p[2]  <= px_b * C_YB;
      s1_p[3]  <= px_r * C_UR;
      s1_p[4]  <= px_g * C_UG;
      s1_p[5]  <= px_b * C_UB;
      s1_p[6]  <= px_r * C_VR;
      s1_p[7]  <= px_g * C_VG;
      s1_p[8]  <= px_b * C_VB;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed sums plus rounding constant.
  // ---------------------------------------------------------------------------
  s18_t s2_y, s2_u, s2_v;
  logic s2_valid, s2_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_odd   <= 1'b0;
      s2_y     <= '0;
      s2_u     <= '0;
      s2_v     <= '0;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_odd   <= s1_odd;
      s2_y     <= s1_p[0] + s1_p[1] + s1_p[2] + ROUND;
      s2_u     <= s1_p[3] + s1_p[4] + s1_p[5] + ROUND;
      s2_v     <= s1_p[6] + s1_p[7] + s1_p[8] + ROUND;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 datapath: >>> floors negative sums, then offset and clamp.
  // ---------------------------------------------------------------------------
  s18_t y_off, u_off, v_off;
  logic [7:0] y_c, u_c, v_c;
  assign y_off = (s2_y >>> 8) + Y_OFF;
  assign u_off = (s2_u >>> 8) + C_OFF;
  assign v_off = (s2_v >>> 8) + C_OFF;
  assign y_c   = clamp8(y_off, Y_MIN, Y_MAX);
  assign u_c   = clamp8(u_off, C_MIN, C_MAX);
  assign v_c   = clamp8(v_off, C_MIN, C_MAX);

`ifdef YUV422_CHROMA_EN
  // ---------------------------------------------------------------------------
  // Stage 3 register, then the pair stage.
  // ---------------------------------------------------------------------------
  logic       s3_valid, s3_odd;
  logic [7:0] s3_y, s3_u, s3_v;

  // Even pixel waiting for its odd partner.
  logic       hold_valid;
  logic [7:0] hold_y, hold_u, hold_v;
  // Odd pixel waiting behind its even partner on the output.
  logic       pend_valid;
  logic [7:0] pend_y, pend_u, pend_v;

  logic       out_free;
  logic [7:0] avg_u, avg_v;

  assign out_free = !out_valid || out_ready;
  // A pending odd pixel owns the next output slot, so nothing else may move.
  assign en       = out_free && !pend_valid;
  assign avg_u    = 8'(({1'b0, hold_u} + {1'b0, s3_u} + 9'd1) >> 1);
  assign avg_v    = 8'(({1'b0, hold_v} + {1'b0, s3_v} + 9'd1) >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      s3_odd   <= 1'b0;
      s3_y     <= '0;
      s3_u     <= '0;
      s3_v     <= '0;
    end else if (en) begin
      s3_valid <= s2_valid;
      s3_odd   <= s2_odd;
      s3_y     <= y_c;
      s3_u     <= u_c;
      s3_v     <= v_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      Y_out      <= '0;
      U_out      <= '0;
      V_out      <= '0;
      hold_valid <= 1'b0;
      hold_y     <= '0;
      hold_u     <= '0;
      hold_v     <= '0;
      pend_valid <= 1'b0;
      pend_y     <= '0;
      pend_u     <= '0;
      pend_v     <= '0;
    end else if (out_free) begin
      out_valid <= 1'b0;
      if (pend_valid) begin
        out_valid  <= 1'b1;
        Y_out      <= pend_y;
        U_out      <= pend_u;
        V_out      <= pend_v;
        pend_valid <= 1'b0;
      end else if (s3_valid) begin
        if (!s3_odd) begin
          // A new even pixel (line restart) flushes an unpaired one as-is.
          if (hold_valid) begin
            out_valid <= 1'b1;
            Y_out     <= hold_y;
            U_out     <= hold_u;
            V_out     <= hold_v;
          end
          hold_valid <= 1'b1;
          hold_y     <= s3_y;
          hold_u     <= s3_u;
          hold_v     <= s3_v;
        end else if (hold_valid) begin
          out_valid  <= 1'b1;
          Y_out      <= hold_y;
          U_out      <= avg_u;
          V_out      <= avg_v;
          pend_valid <= 1'b1;
          pend_y     <= s3_y;
          pend_u     <= avg_u;
          pend_v     <= avg_v;
          hold_valid <= 1'b0;
        end else begin
          // Odd pixel without a held partner passes through unchanged.
          out_valid <= 1'b1;
          Y_out     <= s3_y;
          U_out     <= s3_u;
          V_out     <= s3_v;
        end
      end
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Stage 3 register drives the outputs directly.
  // ---------------------------------------------------------------------------
  assign en = !out_valid || out_ready;

  // Parity is only consumed by the pair stage.
  logic unused_odd;
  assign unused_odd = s2_odd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y_out     <= '0;
      U_out     <= '0;
      V_out     <= '0;
    end else if (en) begin
      out_valid <= s2_valid;
      Y_out     <= y_c;
      U_out     <= u_c;
      V_out     <= v_c;
    end
  end
`endif

endmodule

// File: tb/tb_rgb2yuv_encoder.sv
// -----------------------------------------------------------------------------
// tb_rgb2yuv_encoder
//
// Directed bench for rgb2yuv_encoder (default build). A studio-range instance
// and a full-range instance share the same stimulus. Expected values are
// hand-computed from the conversion equations.
// -----------------------------------------------------------------------------
module tb_rgb2yuv_encoder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r, g, b;
  logic       in_valid, in_sol, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] y, u, v;
  logic       f_in_ready, f_out_valid;
  logic [7:0] fy, fu, fv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rgb2yuv_encoder #(.FULL_RANGE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .R_in(r), .G_in(g), .B_in(b),
    .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol),
    .Y_out(y), .U_out(u), .V_out(v),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rgb2yuv_encoder #(.FULL_RANGE(1'b1)) dut_full (
    .clk(clk), .rst_n(rst_n), .R_in(r), .G_in(g), .B_in(b),
    .in_valid(in_valid), .in_ready(f_in_ready), .in_sol(in_sol),
    .Y_out(fy), .U_out(fu), .V_out(fv),
    .out_valid(f_out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [7:0] r, g, b, y, u, v;
  } vec_t;

  // Studio-range vectors: RGB in, hand-computed YUV out.
  vec_t tbl [10];

  task automatic drive(input vec_t p, input logic sol);
    r        = p.r;
    g        = p.g;
    b        = p.b;
    in_sol   = sol;
    in_valid = 1'b1;
  endtask

  // Streams n table pixels; out_ready is low for cycles [st, st+sl).
  task automatic run_stream(input int n, input int st, input int sl);
    int         sent    = 0;
    int         got     = 0;
    int         cyc     = 0;
    logic       stalled = 1'b0;
    logic [7:0] sy = '0, su = '0, sv = '0;
    while (got < n && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= st && cyc < st + sl);
      if (sent < n) drive(tbl[sent], sent == 0);
      else          in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        check($sformatf("px%0d_y", got), y, tbl[got].y);
        check($sformatf("px%0d_u", got), u, tbl[got].u);
        check($sformatf("px%0d_v", got), v, tbl[got].v);
        got++;
        stalled = 1'b0;
      end else if (out_valid) begin
        check("stall_in_ready", in_ready, 0);
        if (stalled) begin
          check("stall_y_stable", y, sy);
          check("stall_u_stable", u, su);
          check("stall_v_stable", v, sv);
        end
        stalled = 1'b1;
        sy = y;
        su = u;
        sv = v;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    check("stream_count", got, n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    tbl[0] = '{8'd0,   8'd0,   8'd0,   8'd16,  8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd255, 8'd255, 8'd235, 8'd128, 8'd128};
    tbl[2] = '{8'd255, 8'd0,   8'd0,   8'd82,  8'd90,  8'd240};
    tbl[3] = '{8'd0,   8'd0,   8'd255, 8'd41,  8'd240, 8'd110};
    tbl[4] = '{8'd0,   8'd255, 8'd0,   8'd144, 8'd54,  8'd34};
    tbl[5] = '{8'd128, 8'd128, 8'd128, 8'd126, 8'd128, 8'd128};
    tbl[6] = '{8'd255, 8'd255, 8'd0,   8'd210, 8'd16,  8'd146};
    tbl[7] = '{8'd0,   8'd255, 8'd255, 8'd169, 8'd166, 8'd16};
    tbl[8] = '{8'd255, 8'd0,   8'd255, 8'd107, 8'd202, 8'd222};
    tbl[9] = '{8'd16,  8'd32,  8'd64,  8'd43,  8'd144, 8'd119};

    r = '0; g = '0; b = '0;
    in_valid = 1'b0; in_sol = 1'b0; out_ready = 1'b1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_u", u, 0);
    check("rst_v", v, 0);
    check("rst_full_out_valid", f_out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", in_ready, 1);
    check("full_ready_after_rst", f_in_ready, 1);

    // Black then white back to back: 3-cycle latency, both ranges.
    @(negedge clk);
    drive(tbl[0], 1'b1);
    @(negedge clk);
    drive(tbl[1], 1'b0);
    check("lat_c1_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_c2_valid", out_valid, 0);
    @(negedge clk);
    check("black_valid", out_valid, 1);
    check("black_y", y, 16);
    check("black_u", u, 128);
    check("black_v", v, 128);
    check("full_black_valid", f_out_valid, 1);
    check("full_black_y", fy, 0);
    check("full_black_u", fu, 128);
    check("full_black_v", fv, 128);
    @(negedge clk);
    check("white_valid", out_valid, 1);
    check("white_y", y, 235);
    check("white_u", u, 128);
    check("white_v", v, 128);
    check("full_white_y", fy, 255);
    check("full_white_u", fu, 128);
    check("full_white_v", fv, 128);
    @(negedge clk);
    check("drain_valid", out_valid, 0);

    // Red then blue.
    drive(tbl[2], 1'b1);
    @(negedge clk);
    drive(tbl[3], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("red_valid", out_valid, 1);
    check("red_y", y, 82);
    check("red_u", u, 90);
    check("red_v", v, 240);
    @(negedge clk);
    check("blue_valid", out_valid, 1);
    check("blue_y", y, 41);
    check("blue_u", u, 240);
    check("blue_v", v, 110);
    @(negedge clk);
    check("drain2_valid", out_valid, 0);

    // Ten pixels with a five-cycle output stall mid-stream.
    run_stream(10, 5, 5);
    repeat (4) @(negedge clk);

    // Three pixels in flight, then a one-cycle reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(tbl[i + 4], 1'b0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    check("midrst_u", u, 0);
    check("midrst_v", v, 0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    check("ready_after_midrst", in_ready, 1);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("no_ghost_pixels", seen, 0);

    // Fresh pixel after reset still converts correctly.
    @(negedge clk);
    drive(tbl[9], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("post_rst_valid", seen, 1);
    check("post_rst_y", y, 43);
    check("post_rst_u", u, 144);
    check("post_rst_v", v, 119);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
